// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - md_op_e    : operation encodings seen on op_i
//   - md_state_e : FSM state codes
//   - DIV_RESULT_READY / DIV_RESULT_NOT_READY : levels driven on ready_o
//   - helpers decoding signedness and multiply/divide class from an op code
package muldiv_iter_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // State names carry an _S_ infix because MD_DIV already names an op code.
  typedef enum logic [1:0] {
    MD_S_IDLE = 2'b00,
    MD_S_MUL  = 2'b01,
    MD_S_DIV  = 2'b10,
    MD_S_DONE = 2'b11
  } md_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Bit 0 of the op code distinguishes unsigned (1) from signed (0).
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Bit 1 of the op code selects divide (1) over multiply (0).
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Retires STEP result bits by chaining STEP single-bit stages.
// Ports:
//   mode_div_i : 1 = restoring-divide stage, 0 = shift-add multiply stage
//   acc_i      : accumulator in (2*WIDTH+1 bits)
//   operand_i  : multiplicand (multiply) or divisor (divide) magnitude
//   acc_o      : accumulator after STEP bits
// Multiply layout: acc = {0, partial_hi[W-1:0], multiplier_remaining[W-1:0]};
//   the extra top bit holds the adder carry before the right shift.
// Divide layout:   acc = {remainder[W:0], dividend_remaining/quotient[W-1:0]}.
module muldiv_iter_step
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               mode_div_i,
  input  logic [2*WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH:0]   acc_o
);

  logic [2*WIDTH:0] chain [STEP+1];

  assign chain[0] = acc_i;

  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_stage
      logic [WIDTH:0]   mul_sum;
      logic [2*WIDTH:0] mul_next;
      logic [2*WIDTH:0] div_shift;
      logic [WIDTH+1:0] div_diff;
      logic [2*WIDTH:0] div_next;

      // Multiply: add the multiplicand when the current multiplier LSB is
      // set, then shift the whole accumulator right by one.
      assign mul_sum  = chain[gi][2*WIDTH:WIDTH] + (chain[gi][0] ? {1'b0, operand_i} : '0);
      assign mul_next = {1'b0, mul_sum, chain[gi][WIDTH-1:1]};

      // Divide: shift left, trial-subtract the divisor from the upper part;
      // keep the difference and set the quotient bit when no borrow occurs.
      assign div_shift = {chain[gi][2*WIDTH-1:0], 1'b0};
      assign div_diff  = {1'b0, div_shift[2*WIDTH:WIDTH]} - {2'b00, operand_i};
      assign div_next  = div_diff[WIDTH+1] ? div_shift
                                           : {div_diff[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};

      assign chain[gi+1] = mode_div_i ? div_next : mul_next;
    end
  endgenerate

  assign acc_o = chain[STEP];

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) for the EX stage.
// Operates on operand magnitudes and fixes signs once the iterations finish.
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   start_i, op_i          : request and operation (accepted in IDLE, annul_i=0)
//   opdata1_i, opdata2_i   : multiplicand/dividend, multiplier/divisor
//   annul_i                : flush the current operation
//   busy_o                 : operation in flight (MUL, DIV or DONE)
//   ready_o                : one-cycle pulse, hi_o/lo_o/dbz_o valid
//   stall_o                : combinational pipeline stall request
//   dbz_o                  : last divide had a zero divisor
//   hi_o, lo_o             : product high/low, or remainder/quotient
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             stall_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int ITERS = WIDTH / STEP;
  localparam int CNT_W = $clog2(ITERS + 1);

  md_state_e state_q, state_d;

  logic [2*WIDTH:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;      // negate product / quotient
  logic             neg_r_q, neg_r_d;      // negate remainder
  logic             dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  // Request decode
  logic             accept;
  logic             iterating;
  logic             result_ok;
  logic             sgn_op, div_op, zero_div;
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;

  assign sgn_op   = md_is_signed(op_i);
  assign div_op   = md_is_div(op_i);
  assign zero_div = div_op & (opdata2_i == '0);
  assign s1       = sgn_op & opdata1_i[WIDTH-1];
  assign s2       = sgn_op & opdata2_i[WIDTH-1];
  assign mag1     = s1 ? -opdata1_i : opdata1_i;
  assign mag2     = s2 ? -opdata2_i : opdata2_i;

  assign accept    = start_i & (state_q == MD_S_IDLE) & ~annul_i;
  assign iterating = (state_q == MD_S_MUL) | (state_q == MD_S_DIV);
  assign result_ok = (state_q == MD_S_DONE) & ~annul_i;

  muldiv_iter_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .mode_div_i (state_q == MD_S_DIV),
    .acc_i      (acc_q),
    .operand_i  (operand_q),
    .acc_o      (acc_step)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MD_S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_S_IDLE: begin
        if (accept) begin
          if (zero_div)    state_d = MD_S_DONE;
          else if (div_op) state_d = MD_S_DIV;
          else             state_d = MD_S_MUL;
        end
      end
      MD_S_MUL, MD_S_DIV: begin
        if (annul_i)                      state_d = MD_S_IDLE;
        else if (cnt_q == CNT_W'(1))      state_d = MD_S_DONE;
      end
      default: state_d = MD_S_IDLE;   // DONE always returns to IDLE
    endcase
  end

  // ---------------------------------------------------------------- result fix-up
  // In DONE the accumulator holds the final magnitudes; signs are applied here
  // so the corrected result is visible in the ready_o cycle itself.
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod_res = neg_a_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    res_hi   = prod_res[2*WIDTH-1:WIDTH];
    res_lo   = prod_res[WIDTH-1:0];
    if (is_div_q) begin
      if (dbz_pend_q) begin
        // Zero divisor: the raw dividend was parked in the low half.
        res_hi = acc_q[WIDTH-1:0];
        res_lo = '1;
      end else begin
        res_hi = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        res_lo = neg_a_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- datapath next
  always_comb begin
    acc_d      = acc_q;
    operand_d  = operand_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_a_d    = neg_a_q;
    neg_r_d    = neg_r_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;

    if (accept) begin
      cnt_d      = CNT_W'(ITERS);
      is_div_d   = div_op;
      dbz_pend_d = zero_div;
      neg_a_d    = s1 ^ s2;
      neg_r_d    = s1;
      if (div_op) begin
        acc_d     = {{(WIDTH+1){1'b0}}, (zero_div ? opdata1_i : mag1)};
        operand_d = mag2;
      end else begin
        acc_d     = {{(WIDTH+1){1'b0}}, mag2};
        operand_d = mag1;
      end
    end else if (iterating && !annul_i) begin
      acc_d = acc_step;
      cnt_d = cnt_q - CNT_W'(1);
    end

    // Output registers carry the result forward until the next ready_o.
    if (result_ok) begin
      hi_d  = res_hi;
      lo_d  = res_lo;
      dbz_d = dbz_pend_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q      <= '0;
      operand_q  <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      dbz_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      operand_q  <= operand_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_a_q    <= neg_a_d;
      neg_r_q    <= neg_r_d;
      dbz_pend_q <= dbz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dbz_q      <= dbz_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    busy_o  = (state_q != MD_S_IDLE);
    stall_o = accept | iterating;
    ready_o = result_ok ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    hi_o    = result_ok ? res_hi : hi_q;
    lo_o    = result_ok ? res_lo : lo_q;
    dbz_o   = result_ok ? dbz_pend_q : dbz_q;
  end

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with STEP=1
  logic        resetn, start_i, annul_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, ready_o, stall_o, dbz_o;
  logic [31:0] hi_o, lo_o;

  // DUT with STEP=2
  logic        start2, annul2;
  logic [1:0]  op2;
  logic [31:0] a2, b2;
  logic        busy2, ready2, stall2, dbz2;
  logic [31:0] hi2, lo2;

  muldiv_iter #(.WIDTH(32), .STEP(1)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
    .opdata1_i(a_i), .opdata2_i(b_i), .annul_i(annul_i),
    .busy_o(busy_o), .ready_o(ready_o), .stall_o(stall_o), .dbz_o(dbz_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  muldiv_iter #(.WIDTH(32), .STEP(2)) dut2 (
    .clk(clk), .resetn(resetn), .start_i(start2), .op_i(op2),
    .opdata1_i(a2), .opdata2_i(b2), .annul_i(annul2),
    .busy_o(busy2), .ready_o(ready2), .stall_o(stall2), .dbz_o(dbz2),
    .hi_o(hi2), .lo_o(lo2)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic [31:0] start_cyc;
    logic [31:0] lat;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          txn = 0;
  logic [31:0] last_hi, last_lo;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every ready_o pops one expected result.
  always @(negedge clk) begin
    if (resetn && ready_o) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_ready", 64'(ready_o), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        txn++;
        $display("txn %0d: hi=%h lo=%h dbz=%b latency=%0d", txn, hi_o, lo_o, dbz_o,
                 cyc - int'(mon_e.start_cyc));
        check_val("hi", 64'(hi_o), 64'(mon_e.hi));
        check_val("lo", 64'(lo_o), 64'(mon_e.lo));
        check_val("dbz", 64'(dbz_o), 64'(mon_e.dbz));
        check_val("latency", 64'(cyc - int'(mon_e.start_cyc)), 64'(mon_e.lat));
      end
    end
  end

  // Drive a request in the current cycle and queue its expected result.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dbz,
                       input int lat);
    exp_t e;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    e.hi = hi; e.lo = lo; e.dbz = dbz; e.start_cyc = 32'(cyc); e.lat = 32'(lat);
    sb_q.push_back(e);
    last_hi = hi;
    last_lo = lo;
  endtask

  // Wait (bounded) for ready_o, counting the stall cycles on the way.
  task automatic wait_done(input int lat);
    int stall_cnt;
    #1 stall_cnt = int'(stall_o);
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (ready_o) break;
      stall_cnt += int'(stall_o);
    end
    check_val("ready_seen", 64'(ready_o), 64'd1);
    check_val("stall_cycles", 64'(stall_cnt), 64'(lat));
    check_val("stall_in_done", 64'(stall_o), 64'd0);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dbz,
                       input int lat);
    @(negedge clk);
    issue(op, a, b, hi, lo, dbz, lat);
    wait_done(lat);
  endtask

  // STEP=2 instance: one request, checked directly on completion.
  task automatic run2(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] hi, input logic [31:0] lo, input logic dbz,
                      input int lat);
    int n;
    @(negedge clk);
    op2 = op; a2 = a; b2 = b; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 1;
    while (!ready2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    $display("txn step2: hi=%h lo=%h dbz=%b latency=%0d", hi2, lo2, dbz2, n);
    check_val("s2_ready", 64'(ready2), 64'd1);
    check_val("s2_latency", 64'(n), 64'(lat));
    check_val("s2_hi", 64'(hi2), 64'(hi));
    check_val("s2_lo", 64'(lo2), 64'(lo));
    check_val("s2_dbz", 64'(dbz2), 64'(dbz));
    check_val("s2_busy_done", 64'(busy2), 64'd1);
    check_val("s2_stall_done", 64'(stall2), 64'd0);
  endtask

  // Reference model: returns {dbz, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      la, lb;
    logic [63:0] p;
    int          sa, sb;
    logic [31:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_MULT: begin
        la = longint'(sa);
        lb = longint'(sb);
        p  = 64'(la * lb);
        return {1'b0, p};
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      OP_DIV: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {1'b0, r, q};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = a / b;
        r = a % b;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [64:0] rexp;

    resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    start2 = 1'b0; annul2 = 1'b0; op2 = 2'b00; a2 = '0; b2 = '0;
    last_hi = '0; last_lo = '0;

    #1;
    check_val("rst_busy", 64'(busy_o), 64'd0);
    check_val("rst_ready", 64'(ready_o), 64'd0);
    check_val("rst_dbz", 64'(dbz_o), 64'd0);
    check_val("rst_hi", 64'(hi_o), 64'd0);
    check_val("rst_lo", 64'(lo_o), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Directed cases
    do_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33);
    do_op(OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1);
    do_op(OP_MULTU, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0, 33);
    do_op(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33);
    do_op(OP_DIV,   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);
    do_op(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 33);

    // Random cases against the reference model
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 3 == 1) rb = rb >> 24;
      if (i == 5) rb = 32'd0;
      rexp = model(rop, ra, rb);
      do_op(rop, ra, rb, rexp[63:32], rexp[31:0], rexp[64],
            (rop[1] && rb == 32'd0) ? 1 : 33);
    end

    // Annul a DIVU at cycle 10; a new request at cycle 11 is accepted.
    @(negedge clk);
    op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    check_val("annul_busy_before", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check_val("annul_idle", 64'(busy_o), 64'd0);
    check_val("annul_hi_kept", 64'(hi_o), 64'(last_hi));
    check_val("annul_lo_kept", 64'(lo_o), 64'(last_lo));
    issue(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33);
    wait_done(33);

    // Reset at cycle 5 of a MULT, start_i held through reset.
    @(negedge clk);
    issue(OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33);
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    resetn = 1'b0;
    op_i = OP_MULTU; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1;
    sb_q.delete();
    #1;
    check_val("mid_rst_hi", 64'(hi_o), 64'd0);
    check_val("mid_rst_lo", 64'(lo_o), 64'd0);
    check_val("mid_rst_busy", 64'(busy_o), 64'd0);
    check_val("mid_rst_ready", 64'(ready_o), 64'd0);
    check_val("mid_rst_dbz", 64'(dbz_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    issue(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 33);
    wait_done(33);

    // STEP=2 instance
    run2(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 17);
    run2(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 17);
    run2(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 17);
    run2(OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1);

    @(negedge clk);
    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
